// File: rtl/perceptron_uart_ctrl.sv
// Command sequencer between the UART RX/TX FIFOs and the perceptron core.
// Parses 'W' (weights), 'X' (inputs + evaluate) and '?' (ping) packets,
// streams payload bytes into the core register file, runs an evaluation and
// returns a one-byte response. Stalled packets are aborted by a timeout.
module perceptron_uart_ctrl #(
    parameter int N_INPUTS       = 4,
    parameter int AW             = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [7:0]    rx_data,
    input  logic          rx_present,
    output logic          rx_read,
    output logic [7:0]    tx_data,
    output logic          tx_write,
    input  logic          tx_full,
    output logic          core_wr_en,
    output logic          core_wr_sel,
    output logic [AW-1:0] core_wr_addr,
    output logic [7:0]    core_wr_data,
    output logic          core_start,
    input  logic          core_done,
    input  logic [7:0]    core_result
);

    // The byte index must be able to hold N_INPUTS itself (one past the last address).
    localparam int IW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IW-1:0] LAST_COUNT   = IW'(N_INPUTS);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CMD_WEIGHT  = 8'h57;
    localparam logic [7:0] CMD_INPUT   = 8'h58;
    localparam logic [7:0] CMD_PING    = 8'h3F;
    localparam logic [7:0] RSP_PONG    = 8'h21;
    localparam logic [7:0] RSP_ERROR   = 8'h45;
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;
    localparam logic [7:0] RSP_ACK     = 8'h06;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE,
        SEND
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      send_byte;
    logic            bank;
    logic            settle;
    logic [IW-1:0]   index;
    logic [TW-1:0]   timer;

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision and the response byte to queue when entering SEND.
    always_comb begin
        state_next = state;
        send_byte  = tx_data;
        case (state)
            IDLE: begin
                if (rx_read) begin
                    case (rx_data)
                        CMD_WEIGHT, CMD_INPUT: state_next = LOAD;
                        CMD_PING: begin
                            state_next = SEND;
                            send_byte  = RSP_PONG;
                        end
                        default: begin
                            state_next = SEND;
                            send_byte  = RSP_ERROR;
                        end
                    endcase
                end
            end
            LOAD: begin
                if (index == LAST_COUNT) begin
                    if (bank) begin
                        state_next = START;
                    end else begin
                        state_next = SEND;
                        send_byte  = RSP_ACK;
                    end
                end else if (!rx_read && timer == TIMEOUT_LAST) begin
                    state_next = SEND;
                    send_byte  = RSP_TIMEOUT;
                end
            end
            START: state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (core_done) begin
                    state_next = SEND;
                    send_byte  = core_result;
                end
            end
            SEND: begin
                if (!tx_full) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes derived from the current state; a pop is held off for one cycle after each pop.
    always_comb begin
        rx_read    = 1'b0;
        tx_write   = 1'b0;
        core_start = 1'b0;
        if (rx_present && !settle &&
            (state == IDLE || (state == LOAD && index != LAST_COUNT))) begin
            rx_read = 1'b1;
        end
        if (state == SEND && !tx_full) begin
            tx_write = 1'b1;
        end
        if (state == START) begin
            core_start = 1'b1;
        end
    end

    // Datapath: payload writes, byte index, timeout counter and response byte.
    // settle resets high so nothing is popped while the FIFO flags come out of reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            settle       <= 1'b1;
            bank         <= 1'b0;
            index        <= '0;
            timer        <= '0;
            tx_data      <= 8'h00;
            core_wr_en   <= 1'b0;
            core_wr_sel  <= 1'b0;
            core_wr_addr <= '0;
            core_wr_data <= 8'h00;
        end else begin
            settle     <= rx_read;
            core_wr_en <= 1'b0;
            if (state == IDLE && rx_read) begin
                bank <= (rx_data == CMD_INPUT);
            end
            if (state_next != LOAD) begin
                index <= '0;
            end else if (state == LOAD && rx_read) begin
                core_wr_en   <= 1'b1;
                core_wr_sel  <= bank;
                core_wr_addr <= index[AW-1:0];
                core_wr_data <= rx_data;
                index        <= index + 1'b1;
            end
            if (state != LOAD || rx_read) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            if (state != SEND && state_next == SEND) begin
                tx_data <= send_byte;
            end
        end
    end

endmodule

// File: tb/tb_perceptron_uart_ctrl.sv
// Testbench for perceptron_uart_ctrl: RX FIFO model, perceptron core model,
// reference packet model feeding expected-response queues, and an
// independent monitor that checks every TX byte and core write as it appears.
module tb_perceptron_uart_ctrl;

    localparam int N            = 4;
    localparam int AW           = 2;
    localparam int TIMEOUT      = 20;
    localparam int CORE_LATENCY = 10;

    localparam int K_W       = 0;
    localparam int K_X       = 1;
    localparam int K_PING    = 2;
    localparam int K_BAD     = 3;
    localparam int K_X_ABORT = 4;

    logic          CLK;
    logic          RST_N;
    logic [7:0]    rx_data;
    logic          rx_present;
    logic          rx_read;
    logic [7:0]    tx_data;
    logic          tx_write;
    logic          tx_full;
    logic          core_wr_en;
    logic          core_wr_sel;
    logic [AW-1:0] core_wr_addr;
    logic [7:0]    core_wr_data;
    logic          core_start;
    logic          core_done;
    logic [7:0]    core_result;

    int checks;
    int errors;

    logic [7:0]  rx_q[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_wr[$];
    int          exp_start = 0;

    logic [8*N-1:0] ref_w = '0;
    logic [8*N-1:0] ref_x = '0;
    logic [8*N-1:0] core_w = '0;
    logic [8*N-1:0] core_x = '0;

    int cycle          = 0;
    bit pop_pending    = 1'b0;
    bit prev_rx_read   = 1'b0;
    int last_pop_cycle = 0;
    int last_tx_cycle  = 0;
    int done_cycle     = 0;
    bit done_armed     = 1'b0;
    int start_count    = 0;
    int tx_count       = 0;

    perceptron_uart_ctrl #(
        .N_INPUTS      (N),
        .AW            (AW),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .rx_data     (rx_data),
        .rx_present  (rx_present),
        .rx_read     (rx_read),
        .tx_data     (tx_data),
        .tx_write    (tx_write),
        .tx_full     (tx_full),
        .core_wr_en  (core_wr_en),
        .core_wr_sel (core_wr_sel),
        .core_wr_addr(core_wr_addr),
        .core_wr_data(core_wr_data),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_result (core_result)
    );

    // Free-running clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Cycle counter used for latency measurements.
    always @(posedge CLK) cycle <= cycle + 1;

    // Perceptron result: signed dot product, bits [11:4] of the sum.
    function automatic logic [7:0] dotProduct(input logic [8*N-1:0] w, input logic [8*N-1:0] x);
        int acc;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            acc += int'($signed(w[i*8 +: 8])) * int'($signed(x[i*8 +: 8]));
        end
        return acc[11:4];
    endfunction

    function automatic logic [31:0] packWrite(input logic sel, input int addr, input logic [7:0] data);
        logic [7:0] a;
        a = 8'(addr);
        return {15'd0, sel, a, data};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // RX FIFO model: pops after the edge that consumed the head, then refreshes the head.
    initial begin
        rx_present = 1'b0;
        rx_data    = 8'h00;
        forever begin
            @(posedge CLK);
            #1;
            if (pop_pending && rx_q.size() != 0) begin
                void'(rx_q.pop_front());
            end
            #2;
            rx_present = (rx_q.size() != 0);
            rx_data    = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        end
    end

    // Core model: register file fed by the DUT, answers each start after a fixed latency.
    initial begin
        int          countdown;
        logic [7:0]  pending;
        core_done   = 1'b0;
        core_result = 8'h00;
        countdown   = 0;
        pending     = 8'h00;
        forever begin
            @(negedge CLK);
            if (core_wr_en) begin
                if (core_wr_sel) core_x[int'(core_wr_addr)*8 +: 8] = core_wr_data;
                else             core_w[int'(core_wr_addr)*8 +: 8] = core_wr_data;
            end
            if (core_start) begin
                pending   = dotProduct(core_w, core_x);
                countdown = CORE_LATENCY;
            end
            @(posedge CLK);
            #1;
            core_done = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    core_done   = 1'b1;
                    core_result = pending;
                end
            end
        end
    end

    // Monitor: compares every DUT output event against the expected queues.
    always @(negedge CLK) begin
        pop_pending = rx_read;
        if (rx_read) begin
            checkOutput("rx_read_spacing", {31'd0, prev_rx_read}, 32'd0);
            last_pop_cycle = cycle;
        end
        prev_rx_read = rx_read;
        if (core_wr_en) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL core_write_unexpected: got addr %0d data 0x%0h, none required", core_wr_addr, core_wr_data);
            end else begin
                checkOutput("core_write", {15'd0, core_wr_sel, 8'(core_wr_addr), core_wr_data}, exp_wr.pop_front());
            end
        end
        if (core_start) begin
            start_count++;
            checkOutput("start_latency", cycle - last_pop_cycle, 2);
        end
        if (core_done && exp_tx.size() != 0) begin
            done_armed = 1'b1;
            done_cycle = cycle;
        end
        if (tx_write) begin
            tx_count++;
            last_tx_cycle = cycle;
            checkOutput("tx_full_at_write", {31'd0, tx_full}, 32'd0);
            if (exp_tx.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL tx_unexpected: got 0x%0h, no byte required", tx_data);
            end else begin
                checkOutput("tx_byte", tx_data, exp_tx.pop_front());
            end
            if (done_armed) begin
                checkOutput("done_to_tx_latency", cycle - done_cycle, 1);
                done_armed = 1'b0;
            end
        end
    end

    // Reference packet model: queues the bytes and records the expected writes and reply.
    task automatic applyStimulus(input int kind, input logic [7:0] cmd, input logic [8*N-1:0] payload);
        logic [7:0] b;
        @(posedge CLK);
        #2;
        case (kind)
            K_W: begin
                rx_q.push_back(8'h57);
                for (int i = 0; i < N; i++) begin
                    b = payload[i*8 +: 8];
                    rx_q.push_back(b);
                    ref_w[i*8 +: 8] = b;
                    exp_wr.push_back(packWrite(1'b0, i, b));
                end
                exp_tx.push_back(8'h06);
            end
            K_X, K_X_ABORT: begin
                rx_q.push_back(8'h58);
                for (int i = 0; i < N; i++) begin
                    b = payload[i*8 +: 8];
                    rx_q.push_back(b);
                    ref_x[i*8 +: 8] = b;
                    exp_wr.push_back(packWrite(1'b1, i, b));
                end
                exp_start++;
                if (kind == K_X) exp_tx.push_back(dotProduct(ref_w, ref_x));
            end
            K_PING: begin
                rx_q.push_back(8'h3F);
                exp_tx.push_back(8'h21);
            end
            default: begin
                rx_q.push_back(cmd);
                exp_tx.push_back(8'h45);
            end
        endcase
    endtask

    task automatic waitDrain(input int bound);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0 || rx_q.size() != 0) && n < bound) begin
            @(negedge CLK);
            n++;
        end
        if (exp_tx.size() != 0 || exp_wr.size() != 0 || rx_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d tx / %0d writes outstanding, required 0", exp_tx.size(), exp_wr.size());
            exp_tx.delete();
            exp_wr.delete();
            rx_q.delete();
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rx_read"},    {31'd0, rx_read},    32'd0);
        checkOutput({tag, "_tx_write"},   {31'd0, tx_write},   32'd0);
        checkOutput({tag, "_core_wr_en"}, {31'd0, core_wr_en}, 32'd0);
        checkOutput({tag, "_core_start"}, {31'd0, core_start}, 32'd0);
        checkOutput({tag, "_tx_data"},    {24'd0, tx_data},    32'd0);
        checkOutput({tag, "_wr_data"},    {24'd0, core_wr_data}, 32'd0);
        checkOutput({tag, "_wr_addr"},    32'(core_wr_addr),   32'd0);
        checkOutput({tag, "_wr_sel"},     {31'd0, core_wr_sel}, 32'd0);
    endtask

    function automatic logic [7:0] randByte();
        logic [7:0] b;
        case ($urandom_range(0, 9))
            0:       b = 8'h57;
            1:       b = 8'h58;
            2:       b = 8'h3F;
            default: b = 8'($urandom);
        endcase
        return b;
    endfunction

    function automatic logic [8*N-1:0] randPayload();
        logic [8*N-1:0] p;
        for (int i = 0; i < N; i++) p[i*8 +: 8] = randByte();
        return p;
    endfunction

    function automatic logic [7:0] randBadCmd();
        logic [7:0] b;
        b = 8'($urandom);
        while (b == 8'h57 || b == 8'h58 || b == 8'h3F) b = 8'($urandom);
        return b;
    endfunction

    // Global watchdog.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors %0d", errors);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        int tx_before;
        int starts_before;
        int n;
        checks  = 0;
        errors  = 0;
        RST_N   = 1'b0;
        tx_full = 1'b0;

        // Reset with a ping already waiting in the FIFO: nothing may be popped.
        @(posedge CLK);
        #2;
        rx_q.push_back(8'h3F);
        exp_tx.push_back(8'h21);
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("reset_rx_present_seen", {31'd0, rx_present}, 32'd1);
        checkAllZero("reset");
        @(posedge CLK);
        #2;
        RST_N = 1'b1;
        waitDrain(200);

        // Directed weight load and evaluation.
        applyStimulus(K_W, 8'h00, {8'h80, 8'h7F, 8'hFF, 8'h01});
        waitDrain(400);
        applyStimulus(K_X, 8'h00, {8'h40, 8'h30, 8'h20, 8'h10});
        waitDrain(400);

        // Bad command under TX backpressure.
        @(posedge CLK);
        #2;
        tx_full = 1'b1;
        tx_before = tx_count;
        applyStimulus(K_BAD, 8'h41, '0);
        repeat (50) @(negedge CLK);
        checkOutput("tx_held_while_full", tx_count - tx_before, 0);
        checkOutput("response_still_pending", exp_tx.size(), 1);
        @(posedge CLK);
        #2;
        tx_full = 1'b0;
        waitDrain(200);

        // Timeout after one payload byte.
        @(posedge CLK);
        #2;
        rx_q.push_back(8'h58);
        rx_q.push_back(8'h11);
        ref_x[7:0] = 8'h11;
        exp_wr.push_back(packWrite(1'b1, 0, 8'h11));
        exp_tx.push_back(8'h54);
        waitDrain(400);
        checkOutput("timeout_latency", last_tx_cycle - last_pop_cycle, TIMEOUT + 1);
        applyStimulus(K_PING, 8'h00, '0);
        waitDrain(200);

        // Randomised packet mix, sometimes two packets queued back to back.
        for (int it = 0; it < 30; it++) begin
            int reps;
            reps = ($urandom_range(0, 3) == 0) ? 2 : 1;
            for (int r = 0; r < reps; r++) begin
                int kind;
                kind = $urandom_range(0, 3);
                applyStimulus(kind, randBadCmd(), randPayload());
            end
            waitDrain(800);
        end

        // Asynchronous reset while waiting for the core.
        starts_before = start_count;
        applyStimulus(K_X_ABORT, 8'h00, randPayload());
        n = 0;
        while (start_count == starts_before && n < 200) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("abort_start_seen", {31'd0, start_count != starts_before}, 32'd1);
        repeat (3) @(negedge CLK);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        checkAllZero("async_reset");
        repeat (2) @(posedge CLK);
        #2;
        RST_N = 1'b1;
        tx_before = tx_count;
        repeat (20) @(negedge CLK);
        checkOutput("no_tx_after_abort", tx_count - tx_before, 0);
        applyStimulus(K_PING, 8'h00, '0);
        waitDrain(200);

        checkOutput("start_count", start_count, exp_start);
        checkOutput("tx_queue_empty", exp_tx.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
